// File: rtl/decode_pipe.sv
// decode_pipe: register file, operand/branch decode and registered ID/EX stage with load-use interlock
module decode_pipe #(
  parameter int DATA_W   = 16,
  parameter int CTRL_W   = 8,
  parameter int ZERO_REG = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_valid_i,
  output logic              id_ready_o,
  input  logic [15:0]       if_instr_i,
  input  logic [DATA_W-1:0] if_pc_i,
  input  logic              ld_byte_i,
  input  logic              reg_src_i,
  input  logic              branch_src_i,
  input  logic              use_src1_i,
  input  logic              use_src2_i,
  input  logic              mem_read_i,
  input  logic              reg_write_i,
  input  logic [CTRL_W-1:0] ctrl_in_i,
  input  logic              flush_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_dst_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              ex_ready_i,
  output logic              ex_valid_o,
  output logic [DATA_W-1:0] ex_rdata1_o,
  output logic [DATA_W-1:0] ex_rdata2_o,
  output logic [DATA_W-1:0] ex_pc_branch_o,
  output logic [3:0]        ex_src1_o,
  output logic [3:0]        ex_src2_o,
  output logic [3:0]        ex_dst_o,
  output logic              ex_mem_read_o,
  output logic              ex_reg_write_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [15:0]       hazard_cnt_o
);
  localparam bit ZR = ZERO_REG != 0;
  logic [DATA_W-1:0] rf_q [16];
  logic [3:0]        src1, src2, dst;
  logic [DATA_W-1:0] rdata1, rdata2, imm, pc_branch;
  logic              we_ok, hazard, adv, take;
  logic              unused_opc;
  logic              ex_valid_q, ex_valid_d, ex_mem_read_q, ex_mem_read_d, ex_reg_write_q, ex_reg_write_d;
  logic [DATA_W-1:0] ex_rdata1_q, ex_rdata1_d, ex_rdata2_q, ex_rdata2_d, ex_pc_branch_q, ex_pc_branch_d;
  logic [3:0]        ex_src1_q, ex_src1_d, ex_src2_q, ex_src2_d, ex_dst_q, ex_dst_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [15:0]       hazard_cnt_q, hazard_cnt_d;

  assign unused_opc = ^if_instr_i[15:12];
  assign src1 = ld_byte_i ? if_instr_i[11:8] : if_instr_i[7:4];
  assign src2 = reg_src_i ? if_instr_i[11:8] : if_instr_i[3:0];
  assign dst  = if_instr_i[11:8];
  assign we_ok = wb_we_i & ~(ZR && wb_dst_i == 4'd0);
  assign imm = {{(DATA_W-10){if_instr_i[8]}}, if_instr_i[8:0], 1'b0};

  // Operand read with R0 forcing and same-cycle write-back bypass; branch target select
  always_comb begin
    rdata1 = (ZR && src1 == 4'd0) ? '0 : (we_ok && wb_dst_i == src1) ? wb_data_i : rf_q[src1];
    rdata2 = (ZR && src2 == 4'd0) ? '0 : (we_ok && wb_dst_i == src2) ? wb_data_i : rf_q[src2];
    pc_branch = branch_src_i ? rdata1 : if_pc_i + imm;
  end

  assign hazard = if_valid_i & ex_valid_q & ex_mem_read_q & ex_reg_write_q & (ex_dst_q != 4'd0) &
                  ((use_src1_i & ex_dst_q == src1) | (use_src2_i & ex_dst_q == src2));
  assign adv  = ~ex_valid_q | ex_ready_i;
  assign take = ~flush_i & adv & if_valid_i & ~hazard;
  assign id_ready_o = flush_i | (adv & ~hazard);

  // Next ID/EX contents: flush kills, accept loads, free slot without accept bubbles, else hold
  always_comb begin
    ex_valid_d     = flush_i ? 1'b0 : adv ? take : ex_valid_q;
    ex_rdata1_d    = take ? rdata1 : ex_rdata1_q;
    ex_rdata2_d    = take ? rdata2 : ex_rdata2_q;
    ex_pc_branch_d = take ? pc_branch : ex_pc_branch_q;
    ex_src1_d      = take ? src1 : ex_src1_q;
    ex_src2_d      = take ? src2 : ex_src2_q;
    ex_dst_d       = take ? dst : ex_dst_q;
    ex_mem_read_d  = take ? mem_read_i : ex_mem_read_q;
    ex_reg_write_d = take ? reg_write_i : ex_reg_write_q;
    ex_ctrl_d      = take ? ctrl_in_i : ex_ctrl_q;
    hazard_cnt_d   = (hazard & adv & ~flush_i & ~&hazard_cnt_q) ? hazard_cnt_q + 16'd1 : hazard_cnt_q;
  end

  // ID/EX pipeline register and stall counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_q     <= 1'b0;
      ex_rdata1_q    <= '0;
      ex_rdata2_q    <= '0;
      ex_pc_branch_q <= '0;
      ex_src1_q      <= '0;
      ex_src2_q      <= '0;
      ex_dst_q       <= '0;
      ex_mem_read_q  <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_ctrl_q      <= '0;
      hazard_cnt_q   <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rdata1_q    <= ex_rdata1_d;
      ex_rdata2_q    <= ex_rdata2_d;
      ex_pc_branch_q <= ex_pc_branch_d;
      ex_src1_q      <= ex_src1_d;
      ex_src2_q      <= ex_src2_d;
      ex_dst_q       <= ex_dst_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_ctrl_q      <= ex_ctrl_d;
      hazard_cnt_q   <= hazard_cnt_d;
    end
  end

  // Register file write port; suppressed writes to R0 never land
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else if (we_ok) begin
      rf_q[wb_dst_i] <= wb_data_i;
    end
  end

  assign ex_valid_o     = ex_valid_q;
  assign ex_rdata1_o    = ex_rdata1_q;
  assign ex_rdata2_o    = ex_rdata2_q;
  assign ex_pc_branch_o = ex_pc_branch_q;
  assign ex_src1_o      = ex_src1_q;
  assign ex_src2_o      = ex_src2_q;
  assign ex_dst_o       = ex_dst_q;
  assign ex_mem_read_o  = ex_mem_read_q;
  assign ex_reg_write_o = ex_reg_write_q;
  assign ex_ctrl_o      = ex_ctrl_q;
  assign hazard_cnt_o   = hazard_cnt_q;
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed scenario tasks for decode_pipe with hand-computed expectations
module tb_decode_pipe;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_valid, id_ready, ld_byte, reg_src, branch_src, use_src1, use_src2;
  logic        mem_read, reg_write, flush, wb_we, ex_ready, ex_valid, ex_mem_read, ex_reg_write;
  logic [15:0] if_instr, if_pc, wb_data, ex_rdata1, ex_rdata2, ex_pc_branch, hazard_cnt;
  logic [7:0]  ctrl_in, ex_ctrl;
  logic [3:0]  wb_dst, ex_src1, ex_src2, ex_dst;
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  decode_pipe #(.DATA_W(16), .CTRL_W(8), .ZERO_REG(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .if_valid_i(if_valid), .id_ready_o(id_ready),
    .if_instr_i(if_instr), .if_pc_i(if_pc), .ld_byte_i(ld_byte), .reg_src_i(reg_src),
    .branch_src_i(branch_src), .use_src1_i(use_src1), .use_src2_i(use_src2),
    .mem_read_i(mem_read), .reg_write_i(reg_write), .ctrl_in_i(ctrl_in), .flush_i(flush),
    .wb_we_i(wb_we), .wb_dst_i(wb_dst), .wb_data_i(wb_data), .ex_ready_i(ex_ready),
    .ex_valid_o(ex_valid), .ex_rdata1_o(ex_rdata1), .ex_rdata2_o(ex_rdata2),
    .ex_pc_branch_o(ex_pc_branch), .ex_src1_o(ex_src1), .ex_src2_o(ex_src2), .ex_dst_o(ex_dst),
    .ex_mem_read_o(ex_mem_read), .ex_reg_write_o(ex_reg_write), .ex_ctrl_o(ex_ctrl),
    .hazard_cnt_o(hazard_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid = 0; if_instr = 0; if_pc = 0; ld_byte = 0; reg_src = 0; branch_src = 0;
    use_src1 = 0; use_src2 = 0; mem_read = 0; reg_write = 0; ctrl_in = 0; flush = 0;
    wb_we = 0; wb_dst = 0; wb_data = 0; ex_ready = 1;
  endtask

  task automatic wb_write(input logic [3:0] r, input logic [15:0] d);
    wb_we = 1; wb_dst = r; wb_data = d;
    tick();
    wb_we = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #12;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %h exp 0", ex_valid); end
    n_checks++; if (hazard_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_hcnt: got %h exp 0000", hazard_cnt); end
    n_checks++; if (ex_pc_branch !== 16'h0) begin n_fail++; $display("FAIL reset_pcb: got %h exp 0000", ex_pc_branch); end
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_decode();
    wb_write(4'd3, 16'h1234);
    if_valid = 1; if_instr = 16'h0330; if_pc = 16'h0100;
    #1;
    n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL decode_ready: got %h exp 1", id_ready); end
    tick();
    idle();
    n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL decode_valid: got %h exp 1", ex_valid); end
    n_checks++; if (ex_rdata1 !== 16'h1234) begin n_fail++; $display("FAIL decode_rdata1: got %h exp 1234", ex_rdata1); end
    n_checks++; if (ex_src1 !== 4'd3) begin n_fail++; $display("FAIL decode_src1: got %h exp 3", ex_src1); end
    n_checks++; if (ex_dst !== 4'd3) begin n_fail++; $display("FAIL decode_dst: got %h exp 3", ex_dst); end
    tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL idle_bubble: got %h exp 0", ex_valid); end
  endtask

  task automatic test_bypass();
    if_valid = 1; if_instr = 16'h0005; wb_we = 1; wb_dst = 4'd5; wb_data = 16'hBEEF;
    tick();
    idle();
    n_checks++; if (ex_rdata2 !== 16'hBEEF) begin n_fail++; $display("FAIL bypass_rdata2: got %h exp beef", ex_rdata2); end
    if_valid = 1; if_instr = 16'h0000; wb_we = 1; wb_dst = 4'd0; wb_data = 16'hFFFF;
    tick();
    idle();
    n_checks++; if (ex_rdata1 !== 16'h0) begin n_fail++; $display("FAIL r0_bypass: got %h exp 0000", ex_rdata1); end
    if_valid = 1; if_instr = 16'h0500; reg_src = 1;
    tick();
    idle();
    n_checks++; if (ex_rdata1 !== 16'h0) begin n_fail++; $display("FAIL r0_read: got %h exp 0000", ex_rdata1); end
    n_checks++; if (ex_rdata2 !== 16'hBEEF) begin n_fail++; $display("FAIL regsrc_r5: got %h exp beef", ex_rdata2); end
    n_checks++; if (ex_src2 !== 4'd5) begin n_fail++; $display("FAIL regsrc_src2: got %h exp 5", ex_src2); end
  endtask

  task automatic test_branch();
    if_valid = 1; if_instr = 16'h01FE; if_pc = 16'h0010;
    tick();
    n_checks++; if (ex_pc_branch !== 16'h000C) begin n_fail++; $display("FAIL br_neg: got %h exp 000c", ex_pc_branch); end
    if_instr = 16'h0002; if_pc = 16'hFFFE;
    tick();
    idle();
    n_checks++; if (ex_pc_branch !== 16'h0002) begin n_fail++; $display("FAIL br_wrap: got %h exp 0002", ex_pc_branch); end
    wb_write(4'd4, 16'h0400);
    if_valid = 1; if_instr = 16'h0400; if_pc = 16'h0010; branch_src = 1; ld_byte = 1;
    tick();
    idle();
    n_checks++; if (ex_pc_branch !== 16'h0400) begin n_fail++; $display("FAIL br_reg: got %h exp 0400", ex_pc_branch); end
    n_checks++; if (ex_src1 !== 4'd4) begin n_fail++; $display("FAIL ldbyte_src1: got %h exp 4", ex_src1); end
  endtask

  task automatic test_load_use();
    if_valid = 1; if_instr = 16'h0200; mem_read = 1; reg_write = 1;
    tick();
    mem_read = 0; if_instr = 16'h0020;
    #1;
    n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL no_use_ready: got %h exp 1", id_ready); end
    tick();
    n_checks++; if (ex_mem_read !== 1'b0 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL no_use_accept: got v=%h mr=%h exp v=1 mr=0", ex_valid, ex_mem_read); end
    if_instr = 16'h0200; mem_read = 1;
    tick();
    n_checks++; if (ex_mem_read !== 1'b1 || ex_dst !== 4'd2) begin n_fail++; $display("FAIL load_in_ex: got mr=%h dst=%h exp mr=1 dst=2", ex_mem_read, ex_dst); end
    mem_read = 0; if_instr = 16'h0020; use_src1 = 1;
    #1;
    n_checks++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL lu_ready: got %h exp 0", id_ready); end
    tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got %h exp 0", ex_valid); end
    n_checks++; if (hazard_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_hcnt: got %h exp 0001", hazard_cnt); end
    n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL lu_ready2: got %h exp 1", id_ready); end
    tick();
    idle();
    n_checks++; if (ex_valid !== 1'b1 || ex_src1 !== 4'd2) begin n_fail++; $display("FAIL lu_accept: got v=%h s1=%h exp v=1 s1=2", ex_valid, ex_src1); end
    n_checks++; if (hazard_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_hcnt2: got %h exp 0001", hazard_cnt); end
  endtask

  task automatic test_backpressure();
    if_valid = 1; if_instr = 16'h0731; ctrl_in = 8'hA5;
    tick();
    if_instr = 16'h0842; ctrl_in = 8'h5A; ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %h exp 0", i, id_ready); end
      tick();
      n_checks++; if (ex_valid !== 1'b1 || ex_dst !== 4'd7 || ex_ctrl !== 8'hA5 || ex_src1 !== 4'd3)
        begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%h dst=%h ctrl=%h s1=%h exp v=1 dst=7 ctrl=a5 s1=3", i, ex_valid, ex_dst, ex_ctrl, ex_src1); end
    end
    ex_ready = 1;
    #1;
    n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %h exp 1", id_ready); end
    tick();
    idle();
    n_checks++; if (ex_dst !== 4'd8 || ex_ctrl !== 8'h5A) begin n_fail++; $display("FAIL bp_advance: got dst=%h ctrl=%h exp dst=8 ctrl=5a", ex_dst, ex_ctrl); end
  endtask

  task automatic test_flush();
    if_valid = 1; if_instr = 16'h0200; mem_read = 1; reg_write = 1;
    tick();
    mem_read = 0; if_instr = 16'h0020; use_src1 = 1; ex_ready = 0;
    tick();
    n_checks++; if (ex_valid !== 1'b1 || hazard_cnt !== 16'd1) begin n_fail++; $display("FAIL stall_noadv: got v=%h hc=%h exp v=1 hc=0001", ex_valid, hazard_cnt); end
    flush = 1;
    #1;
    n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %h exp 1", id_ready); end
    tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %h exp 0", ex_valid); end
    n_checks++; if (hazard_cnt !== 16'd1) begin n_fail++; $display("FAIL flush_hcnt: got %h exp 0001", hazard_cnt); end
    flush = 0; ex_ready = 1; if_instr = 16'h0200; mem_read = 1; use_src1 = 0;
    tick();
    mem_read = 0; if_instr = 16'h0020; use_src1 = 1; flush = 1;
    tick();
    idle();
    n_checks++; if (ex_valid !== 1'b0 || hazard_cnt !== 16'd1) begin n_fail++; $display("FAIL flush_adv: got v=%h hc=%h exp v=0 hc=0001", ex_valid, hazard_cnt); end
  endtask

  task automatic test_async_reset();
    if_valid = 1; if_instr = 16'h0300; reg_write = 1;
    tick();
    idle();
    n_checks++; if (ex_valid !== 1'b1 || ex_dst !== 4'd3) begin n_fail++; $display("FAIL pre_reset: got v=%h dst=%h exp v=1 dst=3", ex_valid, ex_dst); end
    #2 rst_n = 0;
    #1;
    n_checks++; if (ex_valid !== 1'b0 || ex_dst !== 4'd0 || hazard_cnt !== 16'd0)
      begin n_fail++; $display("FAIL async_reset: got v=%h dst=%h hc=%h exp v=0 dst=0 hc=0000", ex_valid, ex_dst, hazard_cnt); end
    @(negedge clk);
    rst_n = 1;
    if_valid = 1; if_instr = 16'h0330;
    tick();
    idle();
    n_checks++; if (ex_rdata1 !== 16'h0) begin n_fail++; $display("FAIL rf_cleared: got %h exp 0000", ex_rdata1); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_bypass();
    test_branch();
    test_load_use();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_pipe.md
# decode_pipe

Parametrised successor to the single-cycle decode stage for the pipelined CPU. Holds the register file, selects source registers, and computes the branch target (PC-relative or register). Adds a registered ID/EX pipeline stage with a valid/ready handshake, a load-use hazard interlock, a flush input, and a write-back bypass. Sits between fetch (IF/ID) and execute.

## Interface
- DATA_W, 16, data, PC and branch-target width (≥16).
- CTRL_W, 8, width of opaque control bundle passed through to EX.
- ZERO_REG, 1, if 1 then R0 reads 0 and writes to R0 are ignored.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_valid  in  1  upstream instruction valid.
- id_ready  out  1  instruction consumed this cycle.
- if_instr  in  16  instruction: rd=[11:8], rs=[7:4], rt=[3:0], imm9=[8:0].
- if_pc  in  DATA_W  PC+2 of instruction.
- ld_byte, reg_src, branch_src  in  1 each  source-select controls (below).
- use_src1, use_src2  in  1 each  instruction actually reads src1/src2.
- mem_read, reg_write  in  1 each  instruction is a load / writes rd.
- ctrl_in  in  CTRL_W  passthrough controls.
- flush  in  1  kill instruction in ID and ID/EX.
- wb_we  in  1, wb_dst  in  4, wb_data  in  DATA_W  write-back port.
- ex_ready  in  1  downstream accepts.
- ex_valid  out  1; ex_rdata1, ex_rdata2, ex_pc_branch  out  DATA_W; ex_src1, ex_src2, ex_dst  out  4; ex_mem_read, ex_reg_write  out  1; ex_ctrl  out  CTRL_W  — registered ID/EX contents.
- hazard_cnt  out  16  saturating count of load-use stall cycles.

## Operation
- src1 = ld_byte ? instr[11:8] : instr[7:4]; src2 = reg_src ? instr[11:8] : instr[3:0]; dst = instr[11:8].
- Register file: 16 × DATA_W, write on rising clk when wb_we and not (ZERO_REG and wb_dst==0).
- Read bypass: if wb_we and wb_dst==srcN (and write not suppressed), rdataN = wb_data same cycle.
- ZERO_REG=1: reads of R0 return 0 regardless of bypass.
- Branch target: imm = sign-extend(imm9) << 1 to DATA_W; br_imm = if_pc + imm, modulo 2^DATA_W. pc_branch = branch_src ? rdata1 (post-bypass) : br_imm.
- hazard = if_valid & ex_valid & ex_mem_read & ex_reg_write & ex_dst≠0 & ((use_src1 & ex_dst==src1) | (use_src2 & ex_dst==src2)).
- adv = ~ex_valid | ex_ready.
- id_ready = flush | (adv & ~hazard).
- Clock update, priority order:
  - flush: ex_valid←0; ex_* data don't-care; instruction in ID is dropped.
  - else adv & if_valid & ~hazard: load all ex_* from decode; ex_valid←1.
  - else adv: ex_valid←0 (bubble).
  - else: hold all ex_*.
- hazard_cnt increments on each cycle with hazard & adv & ~flush; saturates at 0xFFFF.

## Timing
- Reset (rst=0, async): ex_valid=0, all ex_* = 0, hazard_cnt=0, all registers = 0. Reset mid-stream discards in-flight instruction immediately.
- Latency: 1 cycle, IF/ID to ex_* outputs.
- Load-use: exactly one bubble. The dependent instruction is accepted the cycle after the load leaves EX.
- Back-pressure: with ex_valid=1 and ex_ready=0, id_ready=0 and ex_* stay stable.
- Flush overrides hazard and back-pressure in the same cycle.
- Write in the same cycle as a read of the same register: the bypassed value is captured into ex_rdata.
- id_ready is combinational from inputs and state; no combinational path from ex_ready to ex_* outputs.

## Test plan
- Reset then write R3=0x1234 via wb; decode instr 0x0330 (src1=R3) with if_valid=1 → next cycle ex_valid=1, ex_rdata1=0x1234, ex_src1=3.
- Bypass: wb_we=1, wb_dst=5, wb_data=0xBEEF in the same cycle as decoding src2=R5 → ex_rdata2=0xBEEF; write R0=0xFFFF then read R0 → 0.
- Branch: if_pc=0x0010, imm9=0x1FE (−2), branch_src=0 → ex_pc_branch=0x000C; if_pc=0xFFFE, imm9=0x002 → 0x0002 (wrap); branch_src=1 with R4=0x0400 → 0x0400.
- Load-use: load to R2 in EX (ex_mem_read=1, ex_ready=1), next instr reads R2 with use_src1=1 → id_ready=0, bubble (ex_valid=0), hazard_cnt=1; following cycle the instruction is accepted.
- Back-pressure: ex_ready=0 for 3 cycles with ex_valid=1 → ex_* unchanged, id_ready=0; ex_ready=1 → next instr advances.
- Flush during hazard and ex_ready=0 → id_ready=1, ex_valid=0 next cycle, hazard_cnt unchanged; async reset asserted mid-cycle → ex_valid=0 immediately.
